// File: rtl/imem_loader.sv
// Boot-time loader: assembles little-endian words from a byte stream, writes them
// to instruction memory and holds the CPU in reset until the image is complete.
module imem_loader #(
  parameter int unsigned WORDS     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count,
  output logic [31:0] checksum
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PART_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              state;
  logic [1:0]          byte_idx;
  logic [PART_W-1:0]   partial;
  logic [CNT_W-1:0]    word_count_inc;

  assign word_count_inc = word_count + CNT_W'(1);

  // Only the first three bytes need holding; the fourth goes straight to imem_wdata.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cpu_reset  <= 1'b1;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      word_count <= '0;
      checksum   <= '0;
      byte_idx   <= '0;
      partial    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_COLLECT;
            busy       <= 1'b1;
            byte_ready <= 1'b1;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            imem_addr  <= BASE_ADDR;
            word_count <= '0;
            checksum   <= '0;
            byte_idx   <= '0;
            partial    <= '0;
          end
        end
        ST_COLLECT: begin
          if (byte_valid && byte_ready) begin
            if (byte_idx == 2'd3) begin
              state      <= ST_WRITE;
              byte_ready <= 1'b0;
              imem_we    <= 1'b1;
              imem_wdata <= {byte_data, partial};
              byte_idx   <= '0;
            end else begin
              case (byte_idx)
                2'd0:    partial[7:0]   <= byte_data;
                2'd1:    partial[15:8]  <= byte_data;
                default: partial[23:16] <= byte_data;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        ST_WRITE: begin
          imem_we    <= 1'b0;
          imem_addr  <= imem_addr + 32'd4;
          word_count <= word_count_inc;
          checksum   <= checksum ^ imem_wdata;
          if (word_count_inc == CNT_W'(WORDS)) begin
            state      <= ST_DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            cpu_reset  <= 1'b0;
            byte_ready <= 1'b0;
          end else begin
            state      <= ST_COLLECT;
            byte_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
